// File: rtl/rs_ff_bank_pkg.sv
// Shared definitions for the rs_ff_bank set/reset flip-flop bank.
//   rs_mode_e  : rule applied when set and reset are effective in the same cycle
//   rs_clog2   : ceiling log2, usable in constant expressions
//   rs_selw    : width of the counter-select port, max(1, clog2(nch))
package rs_ff_bank_pkg;

  typedef enum logic [1:0] {
    RS_MODE_RDOM   = 2'd0,  // reset wins
    RS_MODE_SDOM   = 2'd1,  // set wins
    RS_MODE_HOLD   = 2'd2,  // keep current state
    RS_MODE_TOGGLE = 2'd3   // invert current state
  } rs_mode_e;

  function automatic int rs_clog2(input int n);
    int v;
    v = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) v = k + 1;
    end
    return v;
  endfunction

  function automatic int rs_selw(input int nch);
    return (nch <= 2) ? 1 : rs_clog2(nch);
  endfunction

endpackage

// File: rtl/rs_ff_bank_chan.sv
// One set/reset flip-flop channel: input synchroniser, optional rising-edge
// qualification, next-state rule, sticky conflict flag and saturating 0->1 counter.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_r, i_s          raw reset / set requests
//   i_conflict_clr    write-1-to-clear for the conflict flag
//   i_cnt_clr         clear this channel's counter (already qualified by select)
//   o_out             flip-flop state
//   o_conflict        sticky flag: set and reset effective in the same cycle
//   o_cnt             saturating count of 0->1 transitions of o_out
module rs_ff_bank_chan
  import rs_ff_bank_pkg::*;
#(
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE        = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_r,
  input  logic             i_s,
  input  logic             i_conflict_clr,
  input  logic             i_cnt_clr,
  output logic             o_out,
  output logic             o_conflict,
  output logic [CNT_W-1:0] o_cnt
);

  localparam rs_mode_e         P_MODE  = rs_mode_e'(2'(MODE));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_rlvl, w_slvl;
  logic             w_re, w_se;
  logic             w_out_nxt;
  logic             w_rise;
  logic             r_out;
  logic             r_conflict;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser: new samples enter at bit 0, the oldest sample is at the top.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_rlvl = i_r;
    assign w_slvl = i_s;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_rsync, r_ssync;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rsync <= '0;
        r_ssync <= '0;
      end else begin
        r_rsync <= (r_rsync << 1) | SYNC_STAGES'(i_r);
        r_ssync <= (r_ssync << 1) | SYNC_STAGES'(i_s);
      end
    end
    assign w_rlvl = r_rsync[SYNC_STAGES-1];
    assign w_slvl = r_ssync[SYNC_STAGES-1];
  end

  // History flops clear on reset, so a level held across reset release
  // is seen as one rising edge.
  if (EDGE != 0) begin : g_edge
    logic r_rlvl_d, r_slvl_d;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rlvl_d <= 1'b0;
        r_slvl_d <= 1'b0;
      end else begin
        r_rlvl_d <= w_rlvl;
        r_slvl_d <= w_slvl;
      end
    end
    assign w_re = w_rlvl & ~r_rlvl_d;
    assign w_se = w_slvl & ~r_slvl_d;
  end else begin : g_level
    assign w_re = w_rlvl;
    assign w_se = w_slvl;
  end

  always_comb begin
    w_out_nxt = r_out;
    case ({w_se, w_re})
      2'b10:   w_out_nxt = 1'b1;
      2'b01:   w_out_nxt = 1'b0;
      2'b11: begin
        case (P_MODE)
          RS_MODE_RDOM:   w_out_nxt = 1'b0;
          RS_MODE_SDOM:   w_out_nxt = 1'b1;
          RS_MODE_TOGGLE: w_out_nxt = ~r_out;
          default:        w_out_nxt = r_out;
        endcase
      end
      default: w_out_nxt = r_out;
    endcase
  end

  assign w_rise = ~r_out & w_out_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out      <= 1'b0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_out      <= w_out_nxt;
      // A new conflict beats a same-cycle clear.
      r_conflict <= (w_re & w_se) | (r_conflict & ~i_conflict_clr);
      if (i_cnt_clr)
        r_cnt <= '0;
      else if (w_rise && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_out      = r_out;
  assign o_conflict = r_conflict;
  assign o_cnt      = r_cnt;

endmodule

// File: rtl/rs_ff_bank.sv
// Bank of NCH independent set/reset flip-flops with aggregated maskable
// interrupt and counter readback.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   r, s           per-channel reset / set requests
//   irq_en         per-channel interrupt enable
//   conflict_clr   per-channel write-1-to-clear for conflict flags
//   cnt_sel        channel select for counter readback and clear
//   cnt_clr        clear the counter of channel cnt_sel
//   out            flip-flop state
//   conflict       sticky per-channel conflict flags
//   irq            registered |(out & irq_en)
//   cnt_rdata      registered counter of channel cnt_sel (0 if out of range)
module rs_ff_bank
  import rs_ff_bank_pkg::*;
#(
  parameter  int NCH         = 8,
  parameter  int MODE        = 0,
  parameter  int SYNC_STAGES = 2,
  parameter  int EDGE        = 0,
  parameter  int CNT_W       = 8,
  localparam int SELW        = rs_selw(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   r,
  input  logic [NCH-1:0]   s,
  input  logic [NCH-1:0]   irq_en,
  input  logic [NCH-1:0]   conflict_clr,
  input  logic [SELW-1:0]  cnt_sel,
  input  logic             cnt_clr,
  output logic [NCH-1:0]   out,
  output logic [NCH-1:0]   conflict,
  output logic             irq,
  output logic [CNT_W-1:0] cnt_rdata
);

  logic [NCH-1:0]   w_out;
  logic [CNT_W-1:0] w_cnt [NCH];
  logic [CNT_W-1:0] w_rdata_nxt;
  logic             r_irq;
  logic [CNT_W-1:0] r_cnt_rdata;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    // An out-of-range select never matches, so the clear is dropped.
    logic w_cnt_clr;
    assign w_cnt_clr = cnt_clr && (cnt_sel == SELW'(g));

    rs_ff_bank_chan #(
      .MODE        (MODE),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (EDGE),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_r            (r[g]),
      .i_s            (s[g]),
      .i_conflict_clr (conflict_clr[g]),
      .i_cnt_clr      (w_cnt_clr),
      .o_out          (w_out[g]),
      .o_conflict     (conflict[g]),
      .o_cnt          (w_cnt[g])
    );
  end

  always_comb begin
    w_rdata_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cnt_sel == SELW'(k)) w_rdata_nxt = w_cnt[k];
    end
  end

  // Readback samples the counters before this edge's update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq       <= 1'b0;
      r_cnt_rdata <= '0;
    end else begin
      r_irq       <= |(w_out & irq_en);
      r_cnt_rdata <= w_rdata_nxt;
    end
  end

  assign out       = w_out;
  assign irq       = r_irq;
  assign cnt_rdata = r_cnt_rdata;

endmodule

// File: tb/tb_rs_ff_bank.sv
// Randomised and directed stimulus applied to four differently configured
// rs_ff_bank instances, each compared every cycle against a behavioural model.
module tb_rs_ff_bank;

  localparam int NCFG = 4;
  localparam int C_NCH  [NCFG] = '{8, 5, 8, 3};
  localparam int C_MODE [NCFG] = '{0, 1, 2, 3};
  localparam int C_SYNC [NCFG] = '{2, 1, 0, 3};
  localparam int C_EDGE [NCFG] = '{0, 1, 0, 1};
  localparam int C_CNTW [NCFG] = '{8, 2, 3, 2};
  localparam int C_SELW [NCFG] = '{3, 3, 3, 2};

  int cfg_nch  [NCFG] = '{8, 5, 8, 3};
  int cfg_mode [NCFG] = '{0, 1, 2, 3};
  int cfg_sync [NCFG] = '{2, 1, 0, 3};
  int cfg_edge [NCFG] = '{0, 1, 0, 1};
  int cfg_cntw [NCFG] = '{8, 2, 3, 2};
  int cfg_selw [NCFG] = '{3, 3, 3, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] t_r, t_s, t_en, t_cclr;
  logic [2:0] t_sel;
  logic       t_cnt_clr;

  logic [7:0] d_out   [NCFG];
  logic [7:0] d_conf  [NCFG];
  logic [7:0] d_rdata [NCFG];
  logic       d_irq   [NCFG];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit m_out  [NCFG][8];
  bit m_conf [NCFG][8];
  int m_cnt  [NCFG][8];
  bit m_rh   [NCFG][8][4];   // delayed r inputs, index 0 = most recent
  bit m_sh   [NCFG][8][4];
  bit m_rp   [NCFG][8];      // previous effective r level (edge mode)
  bit m_sp   [NCFG][8];
  bit m_irq  [NCFG];
  int m_rd   [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int N  = C_NCH[g];
    localparam int SW = C_SELW[g];
    localparam int CW = C_CNTW[g];
    logic [N-1:0]  l_out, l_conf;
    logic          l_irq;
    logic [CW-1:0] l_rd;

    rs_ff_bank #(
      .NCH         (N),
      .MODE        (C_MODE[g]),
      .SYNC_STAGES (C_SYNC[g]),
      .EDGE        (C_EDGE[g]),
      .CNT_W       (CW)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .r            (t_r[N-1:0]),
      .s            (t_s[N-1:0]),
      .irq_en       (t_en[N-1:0]),
      .conflict_clr (t_cclr[N-1:0]),
      .cnt_sel      (t_sel[SW-1:0]),
      .cnt_clr      (t_cnt_clr),
      .out          (l_out),
      .conflict     (l_conf),
      .irq          (l_irq),
      .cnt_rdata    (l_rd)
    );

    assign d_out[g]   = 8'(l_out);
    assign d_conf[g]  = 8'(l_conf);
    assign d_rdata[g] = 8'(l_rd);
    assign d_irq[g]   = l_irq;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one rising clock edge using the current inputs.
  task automatic model_step();
    for (int c = 0; c < NCFG; c++) begin
      int  n, sel, cmax, sync;
      bit  any;
      n    = cfg_nch[c];
      sync = cfg_sync[c];
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) begin
          m_out[c][i] = 0; m_conf[c][i] = 0; m_cnt[c][i] = 0;
          m_rp[c][i] = 0;  m_sp[c][i] = 0;
          for (int k = 0; k < 4; k++) begin
            m_rh[c][i][k] = 0; m_sh[c][i][k] = 0;
          end
        end
        m_irq[c] = 0;
        m_rd[c]  = 0;
        continue;
      end
      sel  = int'(t_sel) & ((1 << cfg_selw[c]) - 1);
      cmax = (1 << cfg_cntw[c]) - 1;
      m_rd[c] = (sel < n) ? m_cnt[c][sel] : 0;
      any = 0;
      for (int i = 0; i < n; i++) if (m_out[c][i] && t_en[i]) any = 1;
      m_irq[c] = any;
      for (int i = 0; i < n; i++) begin
        bit lr, ls, re, se, nxt;
        lr = (sync == 0) ? t_r[i] : m_rh[c][i][sync-1];
        ls = (sync == 0) ? t_s[i] : m_sh[c][i][sync-1];
        re = cfg_edge[c] != 0 ? (lr && !m_rp[c][i]) : lr;
        se = cfg_edge[c] != 0 ? (ls && !m_sp[c][i]) : ls;
        if (se && !re)       nxt = 1;
        else if (re && !se)  nxt = 0;
        else if (!re && !se) nxt = m_out[c][i];
        else begin
          case (cfg_mode[c])
            0:       nxt = 0;
            1:       nxt = 1;
            2:       nxt = m_out[c][i];
            default: nxt = !m_out[c][i];
          endcase
        end
        if (re && se)       m_conf[c][i] = 1;
        else if (t_cclr[i]) m_conf[c][i] = 0;
        if (t_cnt_clr && sel == i) m_cnt[c][i] = 0;
        else if (!m_out[c][i] && nxt && m_cnt[c][i] < cmax) m_cnt[c][i]++;
        m_out[c][i] = nxt;
        for (int k = 3; k > 0; k--) begin
          m_rh[c][i][k] = m_rh[c][i][k-1];
          m_sh[c][i][k] = m_sh[c][i][k-1];
        end
        m_rh[c][i][0] = t_r[i];
        m_sh[c][i][0] = t_s[i];
        m_rp[c][i] = lr;
        m_sp[c][i] = ls;
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCFG; c++) begin
      logic [7:0] eo, ec;
      eo = '0;
      ec = '0;
      for (int i = 0; i < cfg_nch[c]; i++) begin
        eo[i] = m_out[c][i];
        ec[i] = m_conf[c][i];
      end
      chk($sformatf("c%0d_out", c),       32'(d_out[c]),   32'(eo));
      chk($sformatf("c%0d_conflict", c),  32'(d_conf[c]),  32'(ec));
      chk($sformatf("c%0d_irq", c),       32'(d_irq[c]),   32'(m_irq[c]));
      chk($sformatf("c%0d_cnt_rdata", c), 32'(d_rdata[c]), 32'(m_rd[c]));
    end
  endtask

  task automatic cycle(input logic rn, input logic [7:0] rr, input logic [7:0] ss,
                       input logic [7:0] en, input logic [7:0] cc,
                       input logic [2:0] sel, input logic cclr);
    @(negedge clk);
    rst_n = rn; t_r = rr; t_s = ss; t_en = en; t_cclr = cc;
    t_sel = sel; t_cnt_clr = cclr;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic [7:0] en, input logic [2:0] sel);
    for (int k = 0; k < n; k++) cycle(1'b1, 8'h00, 8'h00, en, 8'h00, sel, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; t_r = '0; t_s = '0; t_en = '0; t_cclr = '0;
    t_sel = '0; t_cnt_clr = 1'b0;

    // Reset with junk on the inputs
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);

    // Single set pulse on channel 0, read its counter back
    idle(2, 8'h00, 3'd0);
    cycle(1'b1, 8'h00, 8'h01, 8'h00, 8'h00, 3'd0, 1'b0);
    idle(6, 8'h00, 3'd0);

    // Set channel 3, then simultaneous r/s, clear, then clear racing a new conflict
    cycle(1'b1, 8'h00, 8'h08, 8'h00, 8'h00, 3'd3, 1'b0);
    idle(5, 8'h00, 3'd3);
    cycle(1'b1, 8'h08, 8'h08, 8'h00, 8'h00, 3'd3, 1'b0);
    idle(5, 8'h00, 3'd3);
    cycle(1'b1, 8'h00, 8'h00, 8'h00, 8'h08, 3'd3, 1'b0);
    idle(2, 8'h00, 3'd3);
    cycle(1'b1, 8'h08, 8'h08, 8'h00, 8'h00, 3'd3, 1'b0);
    for (int k = 0; k < 6; k++) cycle(1'b1, 8'h00, 8'h00, 8'h00, 8'h08, 3'd3, 1'b0);

    // Set held high on channel 1 with a reset pulse in the middle
    for (int k = 0; k < 10; k++)
      cycle(1'b1, (k == 5) ? 8'h02 : 8'h00, 8'h02, 8'h00, 8'h00, 3'd1, 1'b0);
    idle(5, 8'h00, 3'd1);

    // Repeated set/reset on channel 2 to saturate narrow counters, then clear
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 8'h00, 8'h04, 8'h04, 8'h00, 3'd2, 1'b0);
      idle(3, 8'h04, 3'd2);
      cycle(1'b1, 8'h04, 8'h00, 8'h04, 8'h00, 3'd2, 1'b0);
      idle(3, 8'h04, 3'd2);
    end
    cycle(1'b1, 8'h00, 8'h04, 8'h04, 8'h00, 3'd2, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2, 1'b1);
    for (int k = 0; k < 8; k++) idle(1, 8'h00, 3'(k));

    // Reset while set requests are still in the synchronisers
    cycle(1'b1, 8'h00, 8'hff, 8'hff, 8'h00, 3'd0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 8'hff, 8'h00, 3'd0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 8'hff, 8'h00, 3'd0, 1'b0);
    idle(6, 8'hff, 3'd0);

    // Random traffic with sparse requests and occasional resets
    for (int k = 0; k < 2000; k++) begin
      cycle(($urandom_range(0, 99) != 0),
            8'($urandom & $urandom & $urandom),
            8'($urandom & $urandom & $urandom),
            8'($urandom),
            8'($urandom & $urandom),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
